truthtable_capture: RTL
=======================

// Module: truthtable_capture
// PURPOSE
//  Inverse of a truth-table-synthesised function: sweeps every input combination into an
//  external N_IN-input, 1-output combinational function and records its output.
//  Builds the function's truth table plus a minterm count.
//  Sits beside generated truthtable blocks as a self-characterising harness.
//  Result drives checkers or a host register.
// PARAMETERS
//  N_IN           3   number of function inputs; table width is 2**N_IN
//  SETTLE_CYCLES  1   extra cycles each row is held before sampling (0 allowed)
// PORTS
//  clk        in   1          single clock, rising edge
//  reset      in   1          synchronous, active-high
//  start      in   1          request a sweep; honoured only in IDLE or DONE
//  f_in       in   1          output of the function under characterisation
//  x_out      out  N_IN       drive to function inputs; x_out[N_IN-1] = MSB (x3 for N_IN=3)
//  busy       out  1          high while a sweep is in progress
//  done       out  1          one-cycle pulse when the table is complete
//  table_out  out  2**N_IN    bit r = f sampled with x_out==r; updated only at sweep end
//  valid      out  1          table_out holds a complete sweep; cleared by start
//  ones_cnt   out  N_IN+1     popcount of table_out (number of minterms)
// BEHAVIOUR
//  - Reset (sync, active-high) values: state=IDLE, x_out=0, busy=0, done=0, valid=0,
//    table_out=0, ones_cnt=0.
//    Reset mid-sweep aborts the sweep; the partial table is discarded.
//  - States:
//    - IDLE -> HOLD on start.
//    - HOLD -> SAMPLE after SETTLE_CYCLES cycles.
//    - SAMPLE -> HOLD (next row) or -> DONE after the last row.
//    - DONE -> IDLE the next cycle, or -> HOLD if start is high.
//  - Each row r (0 .. 2**N_IN-1, ascending) is held on x_out for exactly SETTLE_CYCLES+1
//    cycles. f_in is sampled on the final rising edge of that window into a shadow register.
//  - On the edge after the last sample:
//    - the shadow register is copied to table_out;
//    - ones_cnt is updated;
//    - valid=1, and done=1 for exactly one cycle.
//  - Latency from the start-sampling edge to done high: 2**N_IN*(SETTLE_CYCLES+1)+1 cycles
//    (17 for the defaults).
//  - start while busy is ignored; a new sweep is not queued.
//  - start in the DONE cycle begins a new sweep immediately: done still pulses, valid drops
//    next cycle.
//  - busy=1 from the edge after start through the last SAMPLE cycle.
//    The row counter wraps to 0 after the last row; x_out returns to 0 in IDLE/DONE.
//  - ones_cnt width N_IN+1 holds the full range 0 .. 2**N_IN without overflow.
// CONFIGURATION
//  TRUTHTABLE_COMPARE_EN defined:
//  - adds input expected[2**N_IN-1:0], sampled on the start edge;
//  - adds outputs mismatch (1 bit) and first_fail[N_IN-1:0], both updated with table_out,
//    reset 0;
//  - mismatch = |(table_out ^ expected);
//  - first_fail = lowest mismatching row index, 0 if none.
//  TRUTHTABLE_COMPARE_EN undefined: these ports and their logic do not exist; all other
//  behaviour is identical.
// STRUCTURE
//  - truthtable_pkg: state enum tt_state_e {IDLE, HOLD, SAMPLE, DONE}; localparam function
//    for TABLE_W = 2**N_IN; settle-counter width helper.
//  - One sub-module, tt_popcount (parameter W, combinational popcount), feeding the
//    ones_cnt register.
//  - Row counter, settle counter and FSM stay in the top level.
// TESTING
//  1 Reset: hold reset 3 cycles -> all outputs 0, state IDLE, x_out=0.
//  2 Defaults, f_in driven by f(x3,x2,x1) with rows 000..111 = 1,1,0,1,0,0,1,0, pulse start
//    -> done 17 cycles later, table_out=8'h4B, ones_cnt=4, valid=1; each x_out value held
//    2 cycles.
//  3 SETTLE_CYCLES=0, f_in = x_out==3'b111 -> table_out=8'h80, ones_cnt=1, done 9 cycles
//    after start.
//  4 Assert reset at row 5 of a sweep, then start again -> first sweep yields no done;
//    second sweep completes with the correct table.
//  5 Pulse start again while busy, then again in the DONE cycle -> mid-sweep pulse ignored;
//    DONE-cycle start begins a new sweep, valid drops next cycle.
//  6 TRUTHTABLE_COMPARE_EN, expected=8'h4B, function with row 6 forced 0 ->
//    table_out=8'h0B, mismatch=1, first_fail=6; with a matching function -> mismatch=0.

Source files
------------

// File: rtl/truthtable_pkg.sv
// Shared types and sizing helpers for the truth-table capture harness.
package truthtable_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

    function automatic int unsigned table_w(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    // Settle counter runs 0 .. settle-1; keep at least one bit so SETTLE_CYCLES=0 still elaborates.
    function automatic int unsigned settle_w(input int unsigned settle);
        return (settle > 32'd1) ? $clog2(settle) : 32'd1;
    endfunction

endpackage

// File: rtl/tt_popcount.sv
// Combinational population count of a W-bit vector.
module tt_popcount #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]       bits,
    output logic [$clog2(W):0] count
);
    localparam int unsigned CW = $clog2(W) + 1;

    // Sum of the set bits
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/truthtable_capture.sv
// Sweeps every input row of an external combinational function and records its truth table.
// Optional TRUTHTABLE_COMPARE_EN adds an expected-table comparison with first failing row.
module truthtable_capture
    import truthtable_pkg::*;
#(
    parameter int unsigned N_IN          = 3,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     f_in,
`ifdef TRUTHTABLE_COMPARE_EN
    input  logic [table_w(N_IN)-1:0] expected,
    output logic                     mismatch,
    output logic [N_IN-1:0]          first_fail,
`endif
    output logic [N_IN-1:0]          x_out,
    output logic                     busy,
    output logic                     done,
    output logic [table_w(N_IN)-1:0] table_out,
    output logic                     valid,
    output logic [N_IN:0]            ones_cnt
);
    localparam int unsigned TABLE_W     = table_w(N_IN);
    localparam int unsigned CNT_W       = settle_w(SETTLE_CYCLES);
    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 32'd0) ? SETTLE_CYCLES - 32'd1 : 32'd0;
    // With no settle time a row goes straight to its sampling cycle.
    localparam tt_state_e       ENTRY_STATE = (SETTLE_CYCLES == 32'd0) ? SAMPLE : HOLD;
    localparam logic [N_IN-1:0] ROW_LAST    = N_IN'(TABLE_W - 32'd1);

    tt_state_e          state_r;
    tt_state_e          next_state_s;
    logic [N_IN-1:0]    row_r;
    logic [N_IN-1:0]    row_next_s;
    logic [N_IN-1:0]    x_out_r;
    logic [CNT_W-1:0]   settle_cnt_r;
    logic               settle_done_s;
    logic               last_row_s;
    logic               accept_s;
    logic               copy_s;
    logic               busy_s;
    logic [TABLE_W-1:0] shadow_r;
    logic [TABLE_W-1:0] table_r;
    logic [N_IN:0]      pop_s;
    logic [N_IN:0]      ones_r;
    logic               busy_r;
    logic               done_r;
    logic               valid_r;

    assign settle_done_s = (state_r == HOLD) && (settle_cnt_r == CNT_W'(SETTLE_LAST));
    assign last_row_s    = (row_r == ROW_LAST);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = start ? ENTRY_STATE : IDLE;
            HOLD:    next_state_s = settle_done_s ? SAMPLE : HOLD;
            SAMPLE:  next_state_s = last_row_s ? DONE : ENTRY_STATE;
            DONE:    next_state_s = start ? ENTRY_STATE : IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM output decode: start acceptance, table commit, next row and busy
    always_comb begin
        accept_s   = 1'b0;
        copy_s     = 1'b0;
        row_next_s = row_r;
        case (state_r)
            IDLE: begin
                accept_s   = start;
                row_next_s = '0;
            end
            HOLD:   row_next_s = row_r;
            SAMPLE: row_next_s = row_r + N_IN'(1'b1);
            DONE: begin
                accept_s   = start;
                copy_s     = 1'b1;
                row_next_s = '0;
            end
            default: row_next_s = '0;
        endcase
        busy_s = (next_state_s == HOLD) || (next_state_s == SAMPLE);
    end

    // Settle counter: counts cycles spent in HOLD for the current row
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt_r <= '0;
        end else if ((state_r == HOLD) && !settle_done_s) begin
            settle_cnt_r <= settle_cnt_r + CNT_W'(1'b1);
        end else begin
            settle_cnt_r <= '0;
        end
    end

    // Row counter; wraps to zero after the last row
    always_ff @(posedge clk) begin
        if (reset) begin
            row_r <= '0;
        end else begin
            row_r <= row_next_s;
        end
    end

    // Shadow table collects one sample per row; cleared when a sweep starts
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r <= '0;
        end else if (accept_s) begin
            shadow_r <= '0;
        end else if (state_r == SAMPLE) begin
            shadow_r[row_r] <= f_in;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    tt_popcount #(
        .W (TABLE_W)
    ) u_popcount (
        .bits  (shadow_r),
        .count (pop_s)
    );

    // Registered drive, busy and done outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            x_out_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            x_out_r <= busy_s ? row_next_s : '0;
            busy_r  <= busy_s;
            done_r  <= copy_s;
        end
    end

    // Result registers; a commit wins over a coincident start, which then clears valid a cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            table_r <= '0;
            ones_r  <= '0;
            valid_r <= 1'b0;
        end else if (copy_s) begin
            table_r <= shadow_r;
            ones_r  <= pop_s;
            valid_r <= 1'b1;
        end else begin
            table_r <= table_r;
            ones_r  <= ones_r;
            valid_r <= (accept_s || busy_r) ? 1'b0 : valid_r;
        end
    end

`ifdef TRUTHTABLE_COMPARE_EN
    logic [TABLE_W-1:0] expected_r;
    logic [TABLE_W-1:0] diff_s;
    logic [N_IN-1:0]    first_fail_s;
    logic               mismatch_r;
    logic [N_IN-1:0]    first_fail_r;

    assign diff_s = shadow_r ^ expected_r;

    // Lowest differing row index, zero when the tables agree
    always_comb begin
        first_fail_s = '0;
        for (int i = TABLE_W - 1; i >= 0; i--) begin
            first_fail_s = diff_s[i] ? N_IN'(i) : first_fail_s;
        end
    end

    // Expected table latched on start; verdict committed alongside table_out
    always_ff @(posedge clk) begin
        if (reset) begin
            expected_r   <= '0;
            mismatch_r   <= 1'b0;
            first_fail_r <= '0;
        end else begin
            expected_r   <= accept_s ? expected : expected_r;
            mismatch_r   <= copy_s ? (|diff_s) : mismatch_r;
            first_fail_r <= copy_s ? first_fail_s : first_fail_r;
        end
    end

    assign mismatch   = mismatch_r;
    assign first_fail = first_fail_r;
`endif

    assign x_out     = x_out_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign table_out = table_r;
    assign valid     = valid_r;
    assign ones_cnt  = ones_r;

endmodule
